matrix_receiver: RTL and testbench
==================================

// Module: matrix_receiver
// PURPOSE
//   GPU-side receiving end of the CPU matrix stream. Tracks matrixState/mtrxOut as driven by
//   the CPU sequencer (states 1..6, each held HOLD cycles), captures each 4x4 Q-format matrix
//   (16 x 16-bit) into a 6-entry bank, checks sequencing, and flags a complete frame to the
//   transform pipeline. Bank is read back through a registered select port.
// PARAMETERS
//   SETTLE  3   consecutive cycles matrixState must be stable before mtrxIn is captured (1..HOLD)
//   HOLD    7   nominal cycles per state from the CPU; used by double-sample check only
// PORTS
//   CLK          in   1    system clock; all logic on posedge
//   rst          in   1    synchronous, active-high reset
//   CPUvalid     in   1    CPU frame-valid; low aborts/ends the frame
//   matrixState  in   4    CPU state: 0 idle, 1 input, 2 rotX, 3 rotY, 4 rotZ, 5 shift, 6 proj, 7..8 end
//   mtrxIn       in   256  signed matrix payload, entry k at [16k+15:16k]
//   rd_sel       in   3    bank read select: 0..5 -> matrix states 1..6; 6,7 -> zero
//   rd_mtrx      out  256  registered bank read data
//   cap_mask     out  6    bit i set once matrix state i+1 captured this frame
//   frame_valid  out  1    one-cycle pulse: all 6 captured, sequence clean
//   seq_err      out  1    sticky sequencing error for current frame
//   frame_cnt    out  8    count of completed frames, wraps 255->0
//   unstable_err out  1    sticky payload-instability flag (only with MRX_DOUBLE_SAMPLE_EN; else 0)
// BEHAVIOUR
//   Reset (rst=1 at posedge): FSM=IDLE; rd_mtrx=0, cap_mask=0, frame_valid=0, seq_err=0,
//     frame_cnt=0, unstable_err=0, prev_state=0, stab_cnt=0; bank cleared to 0. Reset mid-frame
//     discards everything, no frame_valid.
//   Stability: prev_state registers matrixState each cycle; stab_cnt=0 on change, else +1,
//     saturating at 15. Capture of bank[matrixState-1] <= mtrxIn occurs at the edge where
//     stab_cnt==SETTLE-1 and matrixState in 1..6; sets cap_mask bit. Each state captured once.
//   FSM: IDLE -> RECV when CPUvalid=1 (clears cap_mask, seq_err, unstable_err).
//     RECV: legal state changes are 0->1 and n->n+1 (n=1..7). Any other change -> ERR, seq_err=1.
//       Change from state n (1..6) before its capture -> ERR, seq_err=1.
//       Entry to state 7 with cap_mask==6'h3F -> DONE; frame_valid=1 for exactly that cycle;
//       frame_cnt+1.
//     DONE, ERR: hold; no further captures; matrixState 7->8 tolerated in DONE.
//     Any state: CPUvalid=0 -> IDLE next cycle; cap_mask cleared; no frame_valid.
//     CPUvalid falling on the same edge as the state-7 entry: CPUvalid wins, no frame_valid.
//   Bank: updated in place; contents outside a DONE frame may be partial. Retained through IDLE.
//   Read: rd_mtrx <= (rd_sel<6) ? bank[rd_sel] : 0; 1-cycle latency; a capture to the selected
//     entry on the same edge returns the old value (write-after-read).
//   No widening/arith on payload; stored bit-exact.
// CONFIGURATION
//   MRX_DOUBLE_SAMPLE_EN defined: mtrxIn resampled at stab_cnt==HOLD-2 (last cycle of a nominal
//     hold) and compared with the captured value; mismatch sets unstable_err (sticky to next
//     IDLE->RECV) and suppresses frame_valid (FSM -> ERR, seq_err unchanged). If the state changes
//     before the resample point, no compare occurs.
//   Not defined: no second sample, no compare logic, unstable_err tied 0.
// TESTING
//   Nominal frame: CPUvalid=1, states 0,1..6 x7 cycles each, then 7,8; mtrxIn=state*16'h0101
//     replicated -> cap_mask=3F, one frame_valid pulse on state-7 entry, frame_cnt=1, bank[2] reads
//     16'h0303 in all entries one cycle after rd_sel=2.
//   Short hold: state 3 held 2 cycles (SETTLE=3) -> seq_err=1, cap_mask bit2=0, no frame_valid.
//   Skip: state 2 -> 4 -> seq_err=1, FSM ERR; then CPUvalid low 1 cycle, clean frame -> frame_valid,
//     seq_err=0.
//   Abort: CPUvalid drops during state 5 -> cap_mask=0 next cycle, no frame_valid, frame_cnt unchanged.
//   Wrap/reset: 256 clean frames -> frame_cnt=0; rst asserted during state 4 -> all outputs 0 next cycle.
//   MRX_DOUBLE_SAMPLE_EN: mtrxIn changes during cycle 5 of state 6 -> unstable_err=1, no frame_valid.

Source files
------------

// File: rtl/matrix_receiver_if.sv
// rtl/matrix_receiver_if.sv - CPU matrix stream bundle: frame valid, sequencer state, 4x4 payload
interface matrix_receiver_if;
    logic         CPUvalid;
    logic [3:0]   matrixState;
    logic [255:0] mtrxIn;

    modport master (output CPUvalid, matrixState, mtrxIn);
    modport slave  (input  CPUvalid, matrixState, mtrxIn);
endinterface

// File: rtl/matrix_receiver.sv
// rtl/matrix_receiver.sv - captures the 6-matrix CPU stream into a bank, checks sequencing, flags frames
// Optional payload re-check at the end of each hold: MRX_DOUBLE_SAMPLE_EN
module matrix_receiver #(
    parameter int SETTLE = 3,
    parameter int HOLD   = 7
) (
    input  logic             CLK,
    input  logic             rst,
    matrix_receiver_if.slave cpu,
    input  logic [2:0]       rd_sel,
    output logic [255:0]     rd_mtrx,
    output logic [5:0]       cap_mask,
    output logic             frame_valid,
    output logic             seq_err,
    output logic [7:0]       frame_cnt,
    output logic             unstable_err
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_ERR} state_t;

    state_t       r_state, w_next;
    logic [3:0]   r_prev_state, r_stab_cnt;
    logic [255:0] r_bank [6];
    logic [255:0] r_rd_mtrx;
    logic [5:0]   r_cap_mask;
    logic         r_frame_valid, r_seq_err;
    logic [7:0]   r_frame_cnt;

    logic [3:0] w_ms;
    logic [2:0] w_cur_idx, w_prev_idx;
    logic w_change, w_cur_rng, w_prev_rng, w_legal, w_early;
    logic w_settled, w_to_done, w_seq_bad, w_unstable;
    logic w_start, w_capture, w_fire, w_set_seq;

    if (SETTLE < 1 || SETTLE > HOLD || HOLD > 16) begin : g_bad_param
        $error("matrix_receiver: need 1 <= SETTLE <= HOLD <= 16");
    end

    assign w_ms       = cpu.matrixState;
    assign w_cur_idx  = 3'(w_ms - 4'd1);
    assign w_prev_idx = 3'(r_prev_state - 4'd1);
    assign w_change   = (w_ms != r_prev_state);
    assign w_cur_rng  = (w_ms >= 4'd1) && (w_ms <= 4'd6);
    assign w_prev_rng = (r_prev_state >= 4'd1) && (r_prev_state <= 4'd6);
    assign w_legal    = ((r_prev_state == 4'd0) && (w_ms == 4'd1)) ||
                        ((r_prev_state >= 4'd1) && (r_prev_state <= 4'd7) &&
                         (w_ms == r_prev_state + 4'd1));
    assign w_early    = w_prev_rng && !r_cap_mask[w_prev_idx];
    assign w_settled  = !w_change && w_cur_rng && (r_stab_cnt == 4'(SETTLE - 1)) &&
                        !r_cap_mask[w_cur_idx];
    assign w_to_done  = w_change && (r_prev_state == 4'd6) && (w_ms == 4'd7) &&
                        (r_cap_mask == 6'h3F);
    assign w_seq_bad  = w_change && (!w_legal || w_early ||
                        ((w_ms == 4'd7) && (r_cap_mask != 6'h3F)));

`ifdef MRX_DOUBLE_SAMPLE_EN
    // Last cycle of a nominal hold: payload must still match what was captured
    assign w_unstable = !w_change && w_cur_rng && (r_stab_cnt == 4'(HOLD - 2)) &&
                        r_cap_mask[w_cur_idx] && (r_bank[w_cur_idx] != cpu.mtrxIn);
`else
    assign w_unstable = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!cpu.CPUvalid) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_RECV;
                S_RECV:  begin
                    if (w_seq_bad || w_unstable) w_next = S_ERR;
                    else if (w_to_done)          w_next = S_DONE;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_fire    = 1'b0;
        w_set_seq = 1'b0;
        if (cpu.CPUvalid) begin
            case (r_state)
                S_IDLE: w_start = 1'b1;
                S_RECV: begin
                    w_capture = w_settled;
                    w_fire    = w_to_done;
                    w_set_seq = w_seq_bad;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_prev_state  <= '0;
            r_stab_cnt    <= '0;
            r_rd_mtrx     <= '0;
            r_cap_mask    <= '0;
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            r_frame_cnt   <= '0;
            for (int i = 0; i < 6; i++) r_bank[i] <= '0;
        end else begin
            r_prev_state <= w_ms;
            if (w_change)                r_stab_cnt <= '0;
            else if (r_stab_cnt != 4'hF) r_stab_cnt <= r_stab_cnt + 4'd1;
            // Read samples the bank before this edge's capture lands
            r_rd_mtrx <= (rd_sel < 3'd6) ? r_bank[rd_sel] : '0;
            if (w_capture) r_bank[w_cur_idx] <= cpu.mtrxIn;
            if (!cpu.CPUvalid || w_start) r_cap_mask <= '0;
            else if (w_capture)           r_cap_mask[w_cur_idx] <= 1'b1;
            r_frame_valid <= w_fire;
            if (w_fire) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_start)        r_seq_err <= 1'b0;
            else if (w_set_seq) r_seq_err <= 1'b1;
        end
    end

`ifdef MRX_DOUBLE_SAMPLE_EN
    logic r_unstable_err;
    always_ff @(posedge CLK) begin
        if (rst)                                                 r_unstable_err <= 1'b0;
        else if (w_start)                                        r_unstable_err <= 1'b0;
        else if (cpu.CPUvalid && (r_state == S_RECV) && w_unstable) r_unstable_err <= 1'b1;
    end
    assign unstable_err = r_unstable_err;
`else
    assign unstable_err = 1'b0;
`endif

    assign rd_mtrx     = r_rd_mtrx;
    assign cap_mask    = r_cap_mask;
    assign frame_valid = r_frame_valid;
    assign seq_err     = r_seq_err;
    assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_matrix_receiver.sv
// tb/tb_matrix_receiver.sv - randomized self-checking bench for matrix_receiver against a frame-level model
module tb_matrix_receiver;
    localparam int SETTLE = 3;
    localparam int HOLD   = 7;

    logic         CLK = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   rd_sel = 3'd0;
    logic [255:0] rd_mtrx;
    logic [5:0]   cap_mask;
    logic         frame_valid, seq_err, unstable_err;
    logic [7:0]   frame_cnt;

    matrix_receiver_if cpu_if ();

    matrix_receiver #(.SETTLE(SETTLE), .HOLD(HOLD)) dut (
        .CLK(CLK), .rst(rst), .cpu(cpu_if), .rd_sel(rd_sel), .rd_mtrx(rd_mtrx),
        .cap_mask(cap_mask), .frame_valid(frame_valid), .seq_err(seq_err),
        .frame_cnt(frame_cnt), .unstable_err(unstable_err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    // Frame-level model: phase 0 idle, 1 receiving, 2 done, 3 error
    int           m_phase = 0, m_prev = 0, exp_pulses = 0;
    logic [5:0]   m_mask = '0;
    logic         m_err = 1'b0, m_unst = 1'b0;
    logic [7:0]   m_fcnt = '0;
    logic [255:0] m_bank [6];

    int   pulse_cnt = 0, dbl_cnt = 0;
    logic fv_d = 1'b0;
    always @(negedge CLK) begin
        if (frame_valid === 1'b1) pulse_cnt++;
        if (frame_valid === 1'b1 && fv_d === 1'b1) dbl_cnt++;
        fv_d = frame_valid;
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] nom(input int s);
        logic [15:0] w;
        w = 16'(s) * 16'h0101;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int st, input logic v, input logic [255:0] d);
        cpu_if.matrixState = 4'(st);
        cpu_if.CPUvalid    = v;
        cpu_if.mtrxIn      = d;
        tick();
    endtask

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_mask = '0; m_err = 0; m_unst = 0; m_fcnt = '0;
        for (int i = 0; i < 6; i++) m_bank[i] = '0;
    endtask

    task automatic model_change(input int s);
        logic legal, early;
        if (m_phase == 1 && s != m_prev) begin
            legal = (m_prev == 0 && s == 1) || (m_prev >= 1 && m_prev <= 7 && s == m_prev + 1);
            early = (m_prev >= 1 && m_prev <= 6) && !m_mask[m_prev-1];
            if (!legal || early || (s == 7 && m_mask != 6'h3F)) begin
                m_phase = 3; m_err = 1;
            end else if (s == 7) begin
                m_phase = 2; m_fcnt++; exp_pulses++;
            end
        end
        m_prev = s;
    endtask

    task automatic seg(input int s, input int len, input logic [255:0] d);
        model_change(s);
        for (int i = 0; i < len; i++) drive(s, 1'b1, d);
        if (m_phase == 1 && s >= 1 && s <= 6 && len >= SETTLE + 1 && !m_mask[s-1]) begin
            m_bank[s-1] = d; m_mask[s-1] = 1'b1;
        end
    endtask

    task automatic start_frame(input int n_low);
        for (int i = 0; i < n_low; i++) drive(0, 1'b0, '0);
        drive(0, 1'b1, '0);
        drive(0, 1'b1, '0);
        m_phase = 1; m_prev = 0; m_mask = '0; m_err = 0; m_unst = 0;
    endtask

    task automatic abort_frame();
        drive(m_prev, 1'b0, cpu_if.mtrxIn);
        m_phase = 0; m_mask = '0;
    endtask

    task automatic end_frame();
        seg(7, 2, '0);
        seg(8, 2, '0);
    endtask

    task automatic test_reset();
        cpu_if.CPUvalid = 1'b0; cpu_if.matrixState = '0; cpu_if.mtrxIn = '0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_reset();
        n_chk++; if (rd_mtrx !== '0)     begin n_fail++; $display("FAIL reset rd_mtrx got %h exp 0", rd_mtrx); end
        n_chk++; if (cap_mask !== 6'h0)  begin n_fail++; $display("FAIL reset cap_mask got %h exp 0", cap_mask); end
        n_chk++; if (frame_valid !== 0)  begin n_fail++; $display("FAIL reset frame_valid got %b exp 0", frame_valid); end
        n_chk++; if (seq_err !== 0)      begin n_fail++; $display("FAIL reset seq_err got %b exp 0", seq_err); end
        n_chk++; if (frame_cnt !== 8'h0) begin n_fail++; $display("FAIL reset frame_cnt got %0d exp 0", frame_cnt); end
        n_chk++; if (unstable_err !== 0) begin n_fail++; $display("FAIL reset unstable_err got %b exp 0", unstable_err); end
    endtask

    task automatic test_nominal();
        logic [255:0] exp_rd;
        start_frame(1);
        for (int s = 1; s <= 6; s++) seg(s, HOLD, nom(s));
        model_change(7);
        drive(7, 1'b1, '0);
        n_chk++; if (frame_valid !== (m_phase == 2)) begin n_fail++; $display("FAIL nominal pulse_on got %b exp %b", frame_valid, m_phase == 2); end
        drive(7, 1'b1, '0);
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL nominal pulse_off got %b exp 0", frame_valid); end
        seg(8, 2, '0);
        n_chk++; if (cap_mask !== 6'h3F)   begin n_fail++; $display("FAIL nominal cap_mask got %h exp 3f", cap_mask); end
        n_chk++; if (frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL nominal frame_cnt got %0d exp %0d", frame_cnt, m_fcnt); end
        n_chk++; if (pulse_cnt != exp_pulses || dbl_cnt != 0) begin n_fail++; $display("FAIL nominal pulses got %0d/%0d exp %0d/0", pulse_cnt, dbl_cnt, exp_pulses); end
        n_chk++; if (seq_err !== 1'b0)     begin n_fail++; $display("FAIL nominal seq_err got %b exp 0", seq_err); end
        rd_sel = 3'd2; tick();
        exp_rd = {16{16'h0303}};
        n_chk++; if (rd_mtrx !== exp_rd || rd_mtrx !== m_bank[2]) begin n_fail++; $display("FAIL nominal bank2 got %h exp %h", rd_mtrx, exp_rd); end
    endtask

    task automatic test_short_hold();
        int fc0;
        fc0 = exp_pulses;
        start_frame(1);
        seg(1, HOLD, rnd256()); seg(2, HOLD, rnd256()); seg(3, 2, rnd256());
        for (int s = 4; s <= 6; s++) seg(s, HOLD, rnd256());
        end_frame();
        n_chk++; if (seq_err !== 1'b1 || m_err !== 1'b1) begin n_fail++; $display("FAIL short seq_err got %b exp 1", seq_err); end
        n_chk++; if (cap_mask !== m_mask || cap_mask[2] !== 1'b0) begin n_fail++; $display("FAIL short cap_mask got %h exp %h", cap_mask, m_mask); end
        n_chk++; if (pulse_cnt != fc0 || frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL short pulses got %0d cnt %0d exp %0d cnt %0d", pulse_cnt, frame_cnt, fc0, m_fcnt); end
    endtask

    task automatic test_skip();
        start_frame(1);
        seg(1, HOLD, rnd256()); seg(2, HOLD, rnd256()); seg(4, HOLD, rnd256());
        n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL skip seq_err got %b exp 1", seq_err); end
        seg(5, HOLD, rnd256());
        n_chk++; if (cap_mask !== m_mask) begin n_fail++; $display("FAIL skip err_hold cap_mask got %h exp %h", cap_mask, m_mask); end
        abort_frame();
        start_frame(0);
        for (int s = 1; s <= 6; s++) seg(s, HOLD, rnd256());
        end_frame();
        n_chk++; if (seq_err !== 1'b0)  begin n_fail++; $display("FAIL skip recover seq_err got %b exp 0", seq_err); end
        n_chk++; if (pulse_cnt != exp_pulses || frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL skip recover pulses got %0d cnt %0d exp %0d cnt %0d", pulse_cnt, frame_cnt, exp_pulses, m_fcnt); end
    endtask

    task automatic test_abort();
        start_frame(1);
        for (int s = 1; s <= 4; s++) seg(s, HOLD, rnd256());
        seg(5, 3, rnd256());
        abort_frame();
        n_chk++; if (cap_mask !== 6'h0) begin n_fail++; $display("FAIL abort cap_mask got %h exp 0", cap_mask); end
        n_chk++; if (pulse_cnt != exp_pulses || frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL abort pulses got %0d cnt %0d exp %0d cnt %0d", pulse_cnt, frame_cnt, exp_pulses, m_fcnt); end
        // CPUvalid drops on the very edge that enters state 7
        start_frame(1);
        for (int s = 1; s <= 6; s++) seg(s, HOLD, rnd256());
        drive(7, 1'b0, '0);
        m_phase = 0; m_mask = '0; m_prev = 7;
        drive(7, 1'b0, '0);
        n_chk++; if (pulse_cnt != exp_pulses || frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL same_edge pulses got %0d cnt %0d exp %0d cnt %0d", pulse_cnt, frame_cnt, exp_pulses, m_fcnt); end
        n_chk++; if (cap_mask !== 6'h0) begin n_fail++; $display("FAIL same_edge cap_mask got %h exp 0", cap_mask); end
    endtask

    task automatic test_war();
        logic [255:0] d, old;
        start_frame(1);
        rd_sel = 3'd0;
        old = m_bank[0];
        d = rnd256();
        model_change(1);
        for (int i = 0; i < 4; i++) drive(1, 1'b1, d);
        n_chk++; if (rd_mtrx !== old) begin n_fail++; $display("FAIL war old got %h exp %h", rd_mtrx, old); end
        drive(1, 1'b1, d);
        n_chk++; if (rd_mtrx !== d) begin n_fail++; $display("FAIL war new got %h exp %h", rd_mtrx, d); end
        m_bank[0] = d; m_mask[0] = 1'b1;
        n_chk++; if (cap_mask !== m_mask) begin n_fail++; $display("FAIL war cap_mask got %h exp %h", cap_mask, m_mask); end
        abort_frame();
    endtask

    task automatic test_random();
        logic [255:0] d, exp_rd;
        logic aborted;
        int r, sel;
        for (int f = 0; f < 40; f++) begin
            aborted = 1'b0;
            start_frame($urandom_range(1, 2));
            for (int s = 1; s <= 6 && !aborted; s++) begin
                r = $urandom_range(0, 19);
                d = rnd256();
                if (r == 0) continue;
                else if (r == 1) seg(s, $urandom_range(1, SETTLE), d);
                else if (r == 2) begin seg(s, $urandom_range(1, 8), d); abort_frame(); aborted = 1'b1; end
                else seg(s, $urandom_range(SETTLE + 1, 9), d);
            end
            if (!aborted) end_frame();
            n_chk++; if (cap_mask !== m_mask) begin n_fail++; $display("FAIL rand%0d cap_mask got %h exp %h", f, cap_mask, m_mask); end
            n_chk++; if (seq_err !== m_err)   begin n_fail++; $display("FAIL rand%0d seq_err got %b exp %b", f, seq_err, m_err); end
            n_chk++; if (frame_cnt !== m_fcnt || pulse_cnt != exp_pulses || dbl_cnt != 0) begin n_fail++; $display("FAIL rand%0d frames got %0d/%0d exp %0d/%0d", f, frame_cnt, pulse_cnt, m_fcnt, exp_pulses); end
            n_chk++; if (unstable_err !== m_unst) begin n_fail++; $display("FAIL rand%0d unstable_err got %b exp %b", f, unstable_err, m_unst); end
            sel = $urandom_range(0, 7);
            rd_sel = 3'(sel); tick();
            exp_rd = (sel < 6) ? m_bank[sel] : '0;
            n_chk++; if (rd_mtrx !== exp_rd) begin n_fail++; $display("FAIL rand%0d rd sel%0d got %h exp %h", f, sel, rd_mtrx, exp_rd); end
        end
    endtask

    task automatic test_double_sample();
        logic [255:0] d;
        start_frame(1);
        for (int s = 1; s <= 5; s++) seg(s, HOLD, rnd256());
        d = rnd256();
        model_change(6);
        for (int i = 0; i < HOLD; i++) drive(6, 1'b1, (i < 4) ? d : ~d);
        m_bank[5] = d; m_mask[5] = 1'b1;
`ifdef MRX_DOUBLE_SAMPLE_EN
        m_phase = 3; m_unst = 1'b1;
`endif
        end_frame();
        n_chk++; if (unstable_err !== m_unst) begin n_fail++; $display("FAIL dsample unstable_err got %b exp %b", unstable_err, m_unst); end
        n_chk++; if (pulse_cnt != exp_pulses || frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL dsample frames got %0d cnt %0d exp %0d cnt %0d", pulse_cnt, frame_cnt, exp_pulses, m_fcnt); end
        n_chk++; if (seq_err !== m_err) begin n_fail++; $display("FAIL dsample seq_err got %b exp %b", seq_err, m_err); end
        rd_sel = 3'd5; tick();
        n_chk++; if (rd_mtrx !== d) begin n_fail++; $display("FAIL dsample bank5 got %h exp %h", rd_mtrx, d); end
    endtask

    task automatic test_wrap();
        int p0;
        rst = 1'b1; cpu_if.CPUvalid = 1'b0; tick(); rst = 1'b0;
        model_reset();
        p0 = pulse_cnt; exp_pulses = pulse_cnt;
        for (int f = 0; f < 256; f++) begin
            start_frame(1);
            for (int s = 1; s <= 6; s++) seg(s, SETTLE + 1, rnd256());
            end_frame();
        end
        n_chk++; if (frame_cnt !== 8'd0 || m_fcnt !== 8'd0) begin n_fail++; $display("FAIL wrap frame_cnt got %0d exp 0", frame_cnt); end
        n_chk++; if (pulse_cnt - p0 != 256) begin n_fail++; $display("FAIL wrap pulses got %0d exp 256", pulse_cnt - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        start_frame(1);
        for (int s = 1; s <= 3; s++) seg(s, HOLD, rnd256());
        seg(4, 3, rnd256());
        p0 = pulse_cnt;
        rst = 1'b1; tick();
        model_reset();
        n_chk++; if (rd_mtrx !== '0 || cap_mask !== 6'h0 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid outputs got rd %h mask %h fv %b exp 0", rd_mtrx, cap_mask, frame_valid); end
        n_chk++; if (seq_err !== 1'b0 || frame_cnt !== 8'h0 || unstable_err !== 1'b0) begin n_fail++; $display("FAIL rstmid status got se %b cnt %0d ue %b exp 0", seq_err, frame_cnt, unstable_err); end
        rst = 1'b0; cpu_if.CPUvalid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s); tick();
            n_chk++; if (rd_mtrx !== '0) begin n_fail++; $display("FAIL rstmid bank sel%0d got %h exp 0", s, rd_mtrx); end
        end
        n_chk++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL rstmid pulses got %0d exp %0d", pulse_cnt, p0); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_hold();
        test_skip();
        test_abort();
        test_war();
        test_random();
        test_double_sample();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
